// File: rtl/priv_1_12_clint_if.sv
// Single-beat data-bus port of the core-local interruptor.
// The master drives the request; the slave (CLINT) returns data, busy and fault.
interface priv_1_12_clint_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byte_en;
  logic        bus_ren;
  logic        bus_wen;
  logic [31:0] bus_rdata;
  logic        bus_busy;
  logic        bus_fault;

  modport master (
    output bus_addr, bus_wdata, bus_byte_en, bus_ren, bus_wen,
    input  bus_rdata, bus_busy, bus_fault
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_byte_en, bus_ren, bus_wen,
    output bus_rdata, bus_busy, bus_fault
  );
endinterface

// File: rtl/priv_1_12_clint.sv
// Core-local interruptor: memory-mapped mtime/mtimecmp/msip behind a
// two-state bus FSM, producing the machine timer and software interrupt
// sources (plus their one-cycle clear pulses) for the interrupt handler.
module priv_1_12_clint #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  priv_1_12_clint_if.slave      bus,
  output logic                  timer_int_m,
  output logic                  soft_int_m,
  output logic                  clear_timer_int_m,
  output logic                  clear_soft_int_m
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] PRESCALE_LAST = CW'(PRESCALE - 1);

  localparam logic [15:0] OFF_MSIP      = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP0 = 16'h4000;
  localparam logic [15:0] OFF_MTIMECMP1 = 16'h4004;
  localparam logic [15:0] OFF_MTIME0    = 16'hBFF8;
  localparam logic [15:0] OFF_MTIME1    = 16'hBFFC;

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [CW-1:0] r_presc;
  logic [63:0]   r_mtime;
  logic [63:0]   r_mtimecmp;
  logic          r_msip;
  logic [31:0]   r_rdata;
  logic          r_fault;
  logic          r_tint;
  logic          r_ctint;
  logic          r_csoft;

  logic          w_in_win;
  logic          w_req;
  logic          w_accept;
  logic          w_busy;
  logic [15:0]   w_off;
  logic          w_sel_msip;
  logic          w_sel_cmp_lo;
  logic          w_sel_cmp_hi;
  logic          w_sel_mt_lo;
  logic          w_sel_mt_hi;
  logic          w_hit;
  logic          w_wr;
  logic          w_rd;
  logic          w_flt;
  logic          w_tick;
  logic [63:0]   w_mtime_inc;
  logic [63:0]   w_mtime_nxt;
  logic [63:0]   w_cmp_nxt;
  logic          w_msip_nxt;
  logic          w_tint_nxt;
  logic [31:0]   w_rdata_nxt;

  // Replace the byte lanes selected by be with the matching lanes of wd.
  function automatic logic [31:0] f_merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[i*8 +: 8] = wd[i*8 +: 8];
    end
    return res;
  endfunction

  // Address decode: window match, then exact word match (which also
  // rejects any misaligned in-window address).
  always_comb begin
    w_in_win     = (bus.bus_addr[31:16] == BASE_ADDR[31:16]);
    w_req        = (bus.bus_ren | bus.bus_wen) & w_in_win;
    w_off        = bus.bus_addr[15:0];
    w_sel_msip   = (w_off == OFF_MSIP);
    w_sel_cmp_lo = (w_off == OFF_MTIMECMP0);
    w_sel_cmp_hi = (w_off == OFF_MTIMECMP1);
    w_sel_mt_lo  = (w_off == OFF_MTIME0);
    w_sel_mt_hi  = (w_off == OFF_MTIME1);
    w_hit        = w_sel_msip | w_sel_cmp_lo | w_sel_cmp_hi |
                   w_sel_mt_lo | w_sel_mt_hi;
  end

  // Bus FSM next state; busy is raised combinationally while a request is accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_busy      = 1'b1;
          w_accept    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Bus FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Access qualification; write wins when both requests are high.
  always_comb begin
    w_wr  = w_accept &  bus.bus_wen & w_hit;
    w_rd  = w_accept & ~bus.bus_wen & w_hit;
    w_flt = w_accept & ~w_hit;
  end

  // Next-state of the timer and msip: the increment applies to both mtime
  // halves, then a write replaces only the written half's byte lanes, so the
  // unwritten half still carries the increment.
  always_comb begin
    w_tick      = (r_presc == PRESCALE_LAST);
    w_mtime_inc = r_mtime + {63'd0, w_tick};

    w_mtime_nxt = w_mtime_inc;
    if (w_wr && w_sel_mt_lo)
      w_mtime_nxt[31:0]  = f_merge(w_mtime_inc[31:0], bus.bus_wdata, bus.bus_byte_en);
    if (w_wr && w_sel_mt_hi)
      w_mtime_nxt[63:32] = f_merge(w_mtime_inc[63:32], bus.bus_wdata, bus.bus_byte_en);

    w_cmp_nxt = r_mtimecmp;
    if (w_wr && w_sel_cmp_lo)
      w_cmp_nxt[31:0]  = f_merge(r_mtimecmp[31:0], bus.bus_wdata, bus.bus_byte_en);
    if (w_wr && w_sel_cmp_hi)
      w_cmp_nxt[63:32] = f_merge(r_mtimecmp[63:32], bus.bus_wdata, bus.bus_byte_en);

    w_msip_nxt = r_msip;
    if (w_wr && w_sel_msip && bus.bus_byte_en[0])
      w_msip_nxt = bus.bus_wdata[0];

    w_tint_nxt = (w_mtime_nxt >= w_cmp_nxt);
  end

  // Read mux, sampled at the end of the request cycle.
  always_comb begin
    w_rdata_nxt = '0;
    if (w_rd) begin
      if (w_sel_msip)   w_rdata_nxt = {31'd0, r_msip};
      if (w_sel_cmp_lo) w_rdata_nxt = r_mtimecmp[31:0];
      if (w_sel_cmp_hi) w_rdata_nxt = r_mtimecmp[63:32];
      if (w_sel_mt_lo)  w_rdata_nxt = r_mtime[31:0];
      if (w_sel_mt_hi)  w_rdata_nxt = r_mtime[63:32];
    end
  end

  // Timer, compare, msip and prescaler state; mtime writes leave the prescaler alone.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_presc    <= '0;
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
    end else begin
      r_presc    <= w_tick ? '0 : r_presc + 1'b1;
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_cmp_nxt;
      r_msip     <= w_msip_nxt;
    end
  end

  // Response registers: data and fault are valid only in the response cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rdata <= '0;
      r_fault <= 1'b0;
    end else begin
      r_rdata <= w_rdata_nxt;
      r_fault <= w_flt;
    end
  end

  // Interrupt outputs and their falling-edge clear pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tint  <= 1'b0;
      r_ctint <= 1'b0;
      r_csoft <= 1'b0;
    end else begin
      r_tint  <= w_tint_nxt;
      r_ctint <= r_tint & ~w_tint_nxt;
      r_csoft <= r_msip & ~w_msip_nxt;
    end
  end

  assign bus.bus_busy       = w_busy;
  assign bus.bus_rdata      = r_rdata;
  assign bus.bus_fault      = r_fault;
  assign timer_int_m        = r_tint;
  assign soft_int_m         = r_msip;
  assign clear_timer_int_m  = r_ctint;
  assign clear_soft_int_m   = r_csoft;

endmodule

// File: tb/tb_priv_1_12_clint.sv
// Directed bench for priv_1_12_clint: reset state, register reads/writes,
// timer compare, msip, mtime carry, byte enables and fault decoding.
module tb_priv_1_12_clint;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic CLK;
  logic RST;
  logic timer_int_m;
  logic soft_int_m;
  logic clear_timer_int_m;
  logic clear_soft_int_m;

  int checks;
  int errors;

  // Snapshots: s_* one ns after the commit edge (response cycle),
  // s2_* one ns after the following edge.
  logic        s_busy;
  logic [31:0] s_rdata;
  logic        s_fault;
  logic        s_tint, s_ctint, s_soft, s_csoft;
  logic        s2_tint, s2_ctint, s2_soft, s2_csoft, s2_fault;

  priv_1_12_clint_if bus_if ();

  priv_1_12_clint #(
    .BASE_ADDR (BASE),
    .PRESCALE  (1)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .bus               (bus_if.slave),
    .timer_int_m       (timer_int_m),
    .soft_int_m        (soft_int_m),
    .clear_timer_int_m (clear_timer_int_m),
    .clear_soft_int_m  (clear_soft_int_m)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access: drive at negedge, commit at the next posedge, release,
  // then spend the response cycle so the FSM is back in IDLE on return.
  task automatic access(input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be);
    @(negedge CLK);
    bus_if.bus_addr    = addr;
    bus_if.bus_wdata   = data;
    bus_if.bus_byte_en = be;
    bus_if.bus_wen     = wr;
    bus_if.bus_ren     = ~wr;
    #1;
    s_busy = bus_if.bus_busy;
    @(posedge CLK);
    #1;
    bus_if.bus_wen = 1'b0;
    bus_if.bus_ren = 1'b0;
    s_rdata = bus_if.bus_rdata;
    s_fault = bus_if.bus_fault;
    s_tint  = timer_int_m;
    s_ctint = clear_timer_int_m;
    s_soft  = soft_int_m;
    s_csoft = clear_soft_int_m;
    @(posedge CLK);
    #1;
    s2_tint  = timer_int_m;
    s2_ctint = clear_timer_int_m;
    s2_soft  = soft_int_m;
    s2_csoft = clear_soft_int_m;
    s2_fault = bus_if.bus_fault;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus_if.bus_addr    = '0;
    bus_if.bus_wdata   = '0;
    bus_if.bus_byte_en = '0;
    bus_if.bus_ren     = 1'b0;
    bus_if.bus_wen     = 1'b0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;

    // Reset state
    check("rst_tint",   {63'd0, timer_int_m},         64'd0);
    check("rst_soft",   {63'd0, soft_int_m},          64'd0);
    check("rst_ctint",  {63'd0, clear_timer_int_m},   64'd0);
    check("rst_csoft",  {63'd0, clear_soft_int_m},    64'd0);
    check("rst_busy",   {63'd0, bus_if.bus_busy},     64'd0);
    check("rst_fault",  {63'd0, bus_if.bus_fault},    64'd0);
    check("rst_rdata",  {32'd0, bus_if.bus_rdata},    64'd0);

    // mtimecmp reset value
    access(1'b0, BASE + 32'h4000, 32'h0, 4'hF);
    check("busy_req",   {63'd0, s_busy},  64'd1);
    check("cmp_lo_rst", {32'd0, s_rdata}, 64'hFFFF_FFFF);
    check("cmp_lo_flt", {63'd0, s_fault}, 64'd0);
    access(1'b0, BASE + 32'h4004, 32'h0, 4'hF);
    check("cmp_hi_rst", {32'd0, s_rdata}, 64'hFFFF_FFFF);

    // Timer compare: cmp = 10, mtime restarted at 0 on edge E0
    access(1'b1, BASE + 32'h4000, 32'd10, 4'hF);
    check("cmp_lo_wr_tint", {63'd0, s_tint}, 64'd0);
    access(1'b1, BASE + 32'hBFF8, 32'd0, 4'hF);    // commits on E0
    access(1'b1, BASE + 32'h4004, 32'd0, 4'hF);    // commits on E0+2
    check("tint_m2", {63'd0, s_tint},  64'd0);
    check("tint_m3", {63'd0, s2_tint}, 64'd0);     // now at E0+3
    repeat (6) @(posedge CLK);
    #1;
    check("tint_m9", {63'd0, timer_int_m}, 64'd0);
    @(posedge CLK);
    #1;
    check("tint_m10", {63'd0, timer_int_m}, 64'd1);
    repeat (2) @(posedge CLK);
    #1;
    check("tint_hold", {63'd0, timer_int_m}, 64'd1);

    // Raise compare above mtime: interrupt drops with one clear pulse
    access(1'b1, BASE + 32'h4000, 32'hFFFF_FFFF, 4'hF);
    check("tint_fall",    {63'd0, s_tint},   64'd0);
    check("ctint_pulse",  {63'd0, s_ctint},  64'd1);
    check("ctint_single", {63'd0, s2_ctint}, 64'd0);

    // msip set / clear / clear again
    access(1'b1, BASE + 32'h0000, 32'd1, 4'hF);
    check("soft_set",       {63'd0, s_soft},  64'd1);
    check("csoft_on_set",   {63'd0, s_csoft}, 64'd0);
    access(1'b0, BASE + 32'h0000, 32'd0, 4'hF);
    check("msip_read",      {32'd0, s_rdata}, 64'd1);
    check("msip_read_flt",  {63'd0, s_fault}, 64'd0);
    access(1'b1, BASE + 32'h0000, 32'd0, 4'hF);
    check("soft_clr",       {63'd0, s_soft},   64'd0);
    check("csoft_pulse",    {63'd0, s_csoft},  64'd1);
    check("csoft_single",   {63'd0, s2_csoft}, 64'd0);
    access(1'b1, BASE + 32'h0000, 32'd0, 4'hF);
    check("csoft_none",     {63'd0, s_csoft},  64'd0);

    // mtime carry: hi=0, lo=FFFF_FFFF, then read lo and hi
    access(1'b1, BASE + 32'hBFFC, 32'd0, 4'hF);           // G
    access(1'b1, BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF);   // G+2
    access(1'b0, BASE + 32'hBFF8, 32'd0, 4'hF);           // sees value after G+3
    check("carry_lo", {32'd0, s_rdata}, 64'd0);
    access(1'b0, BASE + 32'hBFFC, 32'd0, 4'hF);
    check("carry_hi", {32'd0, s_rdata}, 64'd1);

    // Byte-lane write into mtimecmp_lo (currently FFFF_FFFF)
    access(1'b1, BASE + 32'h4000, 32'hAABB_CCDD, 4'b0010);
    access(1'b0, BASE + 32'h4000, 32'd0, 4'hF);
    check("be_cmp_lo", {32'd0, s_rdata}, 64'hFFFF_CCFF);

    // Faults
    access(1'b0, BASE + 32'h0008, 32'd0, 4'hF);
    check("flt_0008_rd",   {32'd0, s_rdata},  64'd0);
    check("flt_0008",      {63'd0, s_fault},  64'd1);
    check("flt_0008_end",  {63'd0, s2_fault}, 64'd0);
    access(1'b0, BASE + 32'h4002, 32'd0, 4'hF);
    check("flt_4002_rd",   {32'd0, s_rdata},  64'd0);
    check("flt_4002",      {63'd0, s_fault},  64'd1);
    access(1'b1, BASE + 32'h4002, 32'h0, 4'hF);
    access(1'b0, BASE + 32'h4000, 32'd0, 4'hF);
    check("flt_wr_dropped", {32'd0, s_rdata}, 64'hFFFF_CCFF);
    access(1'b0, BASE + 32'h0000, 32'd0, 4'hF);
    check("nofault_0000",  {63'd0, s_fault},  64'd0);

    // Outside the window: no busy, no fault
    access(1'b0, 32'h0000_4000, 32'd0, 4'hF);
    check("oow_busy",  {63'd0, s_busy},  64'd0);
    check("oow_fault", {63'd0, s_fault}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
